commit_trace_fifo: RTL and testbench

// Observation-side counterpart to the clk/reset stimulus driving mips: captures architectural

---
 rtl/commit_trace_fifo.sv | 174 +++++++++++++++++
 tb/tb_commit_trace_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo
// Captures architectural commit events (GRF writes from WB, DM stores from MEM)
// into a small circular FIFO and streams them out over a valid/ready interface.
// Two write ports per cycle (GRF first, since the WB instruction is older than
// the MEM instruction), in-order drain, newest events dropped on overflow with a
// saturating drop counter. The CPU is never back-pressured.

module commit_trace_fifo #(
    parameter int DEPTH = 8,    // power of two, >= 2
    parameter int CNT_W = 16    // drop counter width
) (
    input  logic                     clk,
    input  logic                     reset,     // async, active-low

    // WB-stage register file write
    input  logic                     grf_we,
    input  logic [31:0]              grf_pc,
    input  logic [4:0]               grf_addr,
    input  logic [31:0]              grf_data,

    // MEM-stage data memory store
    input  logic                     dm_we,
    input  logic [31:0]              dm_pc,
    input  logic [31:0]              dm_addr,
    input  logic [31:0]              dm_data,

    // Trace stream
    output logic                     tr_valid,
    input  logic                     tr_ready,
    output logic                     tr_kind,
    output logic [31:0]              tr_pc,
    output logic [31:0]              tr_addr,
    output logic [31:0]              tr_data,

    // Status
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic KIND_GRF = 1'b0;
    localparam logic KIND_DM  = 1'b1;

    // One captured commit event as held in storage.
    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   wr_ptr_p1;

    // ------------------------------------------------------------------
    // Per-cycle decode
    // ------------------------------------------------------------------
    logic            grf_ev;
    logic            dm_ev;
    logic            pop;
    entry_t          grf_entry;
    entry_t          dm_entry;
    entry_t          head;

    logic [LW-1:0]   free;
    logic [1:0]      n_ev;
    logic [1:0]      n_acc;
    logic [1:0]      n_drop;

    logic            wr0_en;
    logic            wr1_en;
    entry_t          wr0_entry;
    entry_t          wr1_entry;

    logic [CNT_W:0]  drop_sum;
    logic [CNT_W-1:0] drop_next;

    // Qualify incoming events, build their storage images and work out how
    // many of them fit into the space available this cycle.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        grf_ev    = grf_we && (grf_addr != 5'd0);   // $0 writes are architecturally invisible
        dm_ev     = dm_we;
        pop       = tr_valid && tr_ready;

        grf_entry = '{kind: KIND_GRF, pc: grf_pc, addr: {27'd0, grf_addr}, data: grf_data};
        dm_entry  = '{kind: KIND_DM,  pc: dm_pc,  addr: dm_addr,           data: dm_data};

        // A slot freed by this cycle's pop is reusable by this cycle's pushes.
        free      = LW'(DEPTH) - level + {{(LW-1){1'b0}}, pop};
        n_ev      = {1'b0, grf_ev} + {1'b0, dm_ev};

        n_acc     = 2'd0;
        if (free >= LW'(2)) begin
            n_acc = n_ev;
        end else if (free == LW'(1)) begin
            n_acc = (n_ev != 2'd0) ? 2'd1 : 2'd0;
        end
        n_drop    = n_ev - n_acc;

        // Accepted events take consecutive slots, oldest (GRF) first, so when
        // only one slot is left the DM event is the one dropped.
        wr0_en    = (n_acc != 2'd0);
        wr0_entry = grf_ev ? grf_entry : dm_entry;
        wr1_en    = (n_acc == 2'd2);
        wr1_entry = dm_entry;

        wr_ptr_p1 = wr_ptr + AW'(1);
    end

    // Saturating drop counter next value.
    always_comb begin
        drop_sum  = {1'b0, drop_cnt} + (CNT_W + 1)'(n_drop);
        drop_next = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end

    // Event storage: written only with accepted events.
    // NOTE: the storage array has no reset; entries are only ever observed
    // through tr_valid, which is derived from the reset level counter.
    always_ff @(posedge clk) begin
        if (wr0_en) begin
            mem[wr_ptr] <= wr0_entry;
        end
        if (wr1_en) begin
            mem[wr_ptr_p1] <= wr1_entry;
        end
    end

    // Pointer, occupancy and drop-count registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            wr_ptr   <= wr_ptr + AW'(n_acc);
            level    <= level + LW'(n_acc) - LW'(pop);
            drop_cnt <= drop_next;
        end
    end

    // Trace outputs come straight from the head entry, forced to zero while
    // empty so unwritten storage never leaks out. Only registered state feeds
    // these, so there is no combinational path from the event inputs.
    always_comb begin
        head     = mem[rd_ptr];
        tr_valid = (level != '0);
        tr_kind  = 1'b0;
        tr_pc    = 32'd0;
        tr_addr  = 32'd0;
        tr_data  = 32'd0;
        if (tr_valid) begin
            tr_kind = head.kind;
            tr_pc   = head.pc;
            tr_addr = head.addr;
            tr_data = head.data;
        end
    end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb_commit_trace_fifo
// Directed bench for commit_trace_fifo: reset state, single and dual events,
// $0 filtering, overflow/drop counting, full+pop, async mid-run reset and
// drop counter saturation. Inputs change and outputs are sampled on the
// falling clock edge.

module tb_commit_trace_fifo;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic              clk;
    logic              reset;
    logic              grf_we;
    logic [31:0]       grf_pc;
    logic [4:0]        grf_addr;
    logic [31:0]       grf_data;
    logic              dm_we;
    logic [31:0]       dm_pc;
    logic [31:0]       dm_addr;
    logic [31:0]       dm_data;
    logic              tr_valid;
    logic              tr_ready;
    logic              tr_kind;
    logic [31:0]       tr_pc;
    logic [31:0]       tr_addr;
    logic [31:0]       tr_data;
    logic [LW-1:0]     level;
    logic [CNT_W-1:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    commit_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .grf_we   (grf_we),
        .grf_pc   (grf_pc),
        .grf_addr (grf_addr),
        .grf_data (grf_data),
        .dm_we    (dm_we),
        .dm_pc    (dm_pc),
        .dm_addr  (dm_addr),
        .dm_data  (dm_data),
        .tr_valid (tr_valid),
        .tr_ready (tr_ready),
        .tr_kind  (tr_kind),
        .tr_pc    (tr_pc),
        .tr_addr  (tr_addr),
        .tr_data  (tr_data),
        .level    (level),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_events();
        grf_we   = 1'b0;
        grf_pc   = 32'd0;
        grf_addr = 5'd0;
        grf_data = 32'd0;
        dm_we    = 1'b0;
        dm_pc    = 32'd0;
        dm_addr  = 32'd0;
        dm_data  = 32'd0;
    endtask

    task automatic set_grf(input logic [31:0] pc, input logic [4:0] addr, input logic [31:0] data);
        grf_we   = 1'b1;
        grf_pc   = pc;
        grf_addr = addr;
        grf_data = data;
    endtask

    task automatic set_dm(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data);
        dm_we   = 1'b1;
        dm_pc   = pc;
        dm_addr = addr;
        dm_data = data;
    endtask

    task automatic check_head(input string tag, input logic kind, input logic [31:0] pc,
                              input logic [31:0] addr, input logic [31:0] data);
        check({tag, ".valid"}, 64'(tr_valid), 64'd1);
        check({tag, ".kind"},  64'(tr_kind),  64'(kind));
        check({tag, ".pc"},    64'(tr_pc),    64'(pc));
        check({tag, ".addr"},  64'(tr_addr),  64'(addr));
        check({tag, ".data"},  64'(tr_data),  64'(data));
    endtask

    initial begin
        reset    = 1'b0;
        tr_ready = 1'b0;
        clear_events();

        // T1: reset then idle
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("t1.valid", 64'(tr_valid), 64'd0);
        check("t1.level", 64'(level),    64'd0);
        check("t1.drop",  64'(drop_cnt), 64'd0);
        check("t1.kind",  64'(tr_kind),  64'd0);
        check("t1.pc",    64'(tr_pc),    64'd0);
        check("t1.addr",  64'(tr_addr),  64'd0);
        check("t1.data",  64'(tr_data),  64'd0);

        // T2: single GRF event, consumer ready
        set_grf(32'h3000, 5'd5, 32'h1234);
        tr_ready = 1'b1;
        @(negedge clk);
        clear_events();
        check_head("t2.head", 1'b0, 32'h3000, 32'd5, 32'h1234);
        check("t2.level1", 64'(level), 64'd1);
        @(negedge clk);
        check("t2.level0", 64'(level),    64'd0);
        check("t2.valid0", 64'(tr_valid), 64'd0);

        // T3: GRF and DM in the same cycle, GRF comes out first
        tr_ready = 1'b0;
        set_grf(32'h3008, 5'd8, 32'hAAAA);
        set_dm(32'h300C, 32'h10, 32'hBBBB);
        @(negedge clk);
        clear_events();
        check("t3.level2", 64'(level), 64'd2);
        check_head("t3.first", 1'b0, 32'h3008, 32'd8, 32'hAAAA);
        tr_ready = 1'b1;
        @(negedge clk);
        check_head("t3.second", 1'b1, 32'h300C, 32'h10, 32'hBBBB);
        check("t3.level1", 64'(level), 64'd1);
        @(negedge clk);
        check("t3.level0", 64'(level), 64'd0);
        tr_ready = 1'b0;

        // T4: write to $0 is ignored and not counted as a drop
        set_grf(32'h3010, 5'd0, 32'hDEAD);
        @(negedge clk);
        clear_events();
        check("t4.level", 64'(level),    64'd0);
        check("t4.drop",  64'(drop_cnt), 64'd0);
        check("t4.valid", 64'(tr_valid), 64'd0);

        // T5a: 10 events into 8 slots, last cycle's pair dropped
        for (int c = 0; c < 5; c++) begin
            set_grf(32'h4000 + 32'(8 * c), 5'(c + 1), 32'h100 + 32'(c));
            set_dm(32'h4004 + 32'(8 * c), 32'h200 + 32'(4 * c), 32'h900 + 32'(c));
            @(negedge clk);
        end
        clear_events();
        check("t5.level_full", 64'(level),    64'd8);
        check("t5.drop2",      64'(drop_cnt), 64'd2);

        // T5b: drain returns the first 8 events in order
        tr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int c;
            c = k / 2;
            if (k % 2 == 0)
                check_head($sformatf("t5.drain%0d", k), 1'b0, 32'h4000 + 32'(8 * c),
                           32'(c + 1), 32'h100 + 32'(c));
            else
                check_head($sformatf("t5.drain%0d", k), 1'b1, 32'h4004 + 32'(8 * c),
                           32'h200 + 32'(4 * c), 32'h900 + 32'(c));
            @(negedge clk);
        end
        check("t5.level_empty", 64'(level), 64'd0);
        tr_ready = 1'b0;

        // T5c: refill, then full + pop + two events
        for (int c = 0; c < 4; c++) begin
            set_grf(32'h5000 + 32'(8 * c), 5'(c + 1), 32'h500 + 32'(c));
            set_dm(32'h5004 + 32'(8 * c), 32'h300 + 32'(4 * c), 32'h700 + 32'(c));
            @(negedge clk);
        end
        check("t5.refill_level", 64'(level), 64'd8);
        set_grf(32'h6000, 5'd9, 32'h6666);
        set_dm(32'h6004, 32'h400, 32'h7777);
        tr_ready = 1'b1;
        @(negedge clk);
        clear_events();
        check("t5.fullpop_level", 64'(level),    64'd8);
        check("t5.fullpop_drop",  64'(drop_cnt), 64'd3);
        check_head("t5.fullpop_head", 1'b1, 32'h5004, 32'h300, 32'h700);
        repeat (7) @(negedge clk);
        check_head("t5.tail", 1'b0, 32'h6000, 32'd9, 32'h6666);
        check("t5.tail_level", 64'(level), 64'd1);
        @(negedge clk);
        tr_ready = 1'b0;
        check("t5.empty_again", 64'(level), 64'd0);

        // T6: async reset with 3 entries pending
        set_grf(32'h6100, 5'd1, 32'h11);
        set_dm(32'h6104, 32'h40, 32'h22);
        @(negedge clk);
        clear_events();
        set_grf(32'h6108, 5'd2, 32'h33);
        @(negedge clk);
        clear_events();
        check("t6.level3", 64'(level), 64'd3);
        #2;
        reset = 1'b0;
        #1;
        check("t6.rst_valid", 64'(tr_valid), 64'd0);
        check("t6.rst_level", 64'(level),    64'd0);
        check("t6.rst_drop",  64'(drop_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        set_grf(32'h7000, 5'd3, 32'h77);
        @(negedge clk);
        clear_events();
        check_head("t6.first_after", 1'b0, 32'h7000, 32'd3, 32'h77);
        check("t6.level1", 64'(level), 64'd1);

        // T7: drop counter saturates at all-ones. From level 1: three cycles
        // accept 2 each, the fourth accepts 1 and drops 1, then 2 drops per cycle.
        set_grf(32'h8000, 5'd4, 32'h88);
        set_dm(32'h8004, 32'h80, 32'h99);
        repeat (4 + 32766) @(negedge clk);
        check("t7.drop_pre", 64'(drop_cnt), 64'd65533);
        @(negedge clk);
        check("t7.drop_sat", 64'(drop_cnt), 64'd65535);
        @(negedge clk);
        check("t7.drop_hold", 64'(drop_cnt), 64'd65535);
        check("t7.level", 64'(level), 64'd8);
        clear_events();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
